// File: rtl/chrono_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding, field widths, default limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chrono_pkg;

   // Widths of the displayed fields; these are fixed by the display interface.
   localparam int CS_W  = 7;
   localparam int SEC_W = 6;
   localparam int MIN_W = 6;

   // Default roll-over points: 99 cs, 59 s, 59 min (minutes saturate).
   localparam int CS_MAX_DEF  = 99;
   localparam int SEC_MAX_DEF = 59;
   localparam int MIN_MAX_DEF = 59;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   // One elapsed-time value as shown on the display.
   typedef struct packed {
      logic [MIN_W-1:0] min;
      logic [SEC_W-1:0] sec;
      logic [CS_W-1:0]  cs;
   } tstamp_t;

   // The live counter advances only in these states.
   function automatic logic is_running(input state_t s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter stage with enable, freeze, sync clear and carry-out for cascading.
// Latency: count changes on the edge where en=1; carry and nxt are combinational.
// Backpressure: none; frz holds the count even when en=1.
//
// Ports:
//   clk_in, rst_n : clock, asynchronous active-low reset
//   clr           : synchronous clear to zero (wins over en)
//   en            : advance by one this edge (wraps MAX -> 0)
//   frz           : hold the count regardless of en (saturation of the whole cascade)
//   cnt           : current count
//   nxt           : value the count takes on the coming edge
//   carry         : en while at MAX, i.e. the enable for the next stage
module mod_counter #(
   parameter int W   = 7,
   parameter int MAX = 99
) (
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         frz,
   output logic [W-1:0] cnt,
   output logic [W-1:0] nxt,
   output logic         carry
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         at_max;

   assign at_max = (cnt_q == MAX_V);

   // Carry ignores frz on purpose: the top stage's carry is what detects
   // the saturating tick, and that detection drives frz.
   assign carry = en & at_max;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !frz) begin
         cnt_d = at_max ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign nxt = cnt_d;

endmodule

// File: rtl/chrono_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP FSM, cascaded mm:ss.cc counter, lap snapshot, display regs.
// Latency: 1 cycle from tick/button to registered outputs.
// Backpressure: none; every tick and button pulse is consumed on the cycle it arrives.
//
// Ports:
//   clk_in, rst_n              : clock, asynchronous active-low reset
//   tick                       : 1/100 s pulse from the external divider
//   btn_ss, btn_lap, btn_clr   : debounced one-cycle button pulses (clr > ss > lap)
//   disp_cs, disp_sec, disp_min: registered display (snapshot in LAP, live otherwise)
//   running, lap_hold, ovf     : registered status (RUN|LAP, LAP, sticky saturation)
module chrono_ctrl
   import chrono_pkg::*;
#(
   parameter int CS_MAX  = CS_MAX_DEF,
   parameter int SEC_MAX = SEC_MAX_DEF,
   parameter int MIN_MAX = MIN_MAX_DEF
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             btn_ss,
   input  logic             btn_lap,
   input  logic             btn_clr,
   output logic [CS_W-1:0]  disp_cs,
   output logic [SEC_W-1:0] disp_sec,
   output logic [MIN_W-1:0] disp_min,
   output logic             running,
   output logic             lap_hold,
   output logic             ovf
);

   state_t state_q, state_d;

   tstamp_t snap_q, snap_d;
   tstamp_t disp_q, disp_d;
   logic    running_q, running_d;
   logic    lap_hold_q, lap_hold_d;
   logic    ovf_q, ovf_d;

   tstamp_t live_q;
   tstamp_t live_nxt;

   logic             run_tick;
   logic             ovf_hit;
   logic             clr_hit;
   logic             cs_carry, sec_carry, min_carry;
   logic [CS_W-1:0]  cs_cnt, cs_nxt;
   logic [SEC_W-1:0] sec_cnt, sec_nxt;
   logic [MIN_W-1:0] min_cnt, min_nxt;

   // Ticks count according to the state held before the edge, so a tick
   // arriving with btn_ss in RUN is counted and one in IDLE/PAUSE is not.
   assign run_tick = tick & is_running(state_q);

   // A carry out of the minutes stage means the counter is at its ceiling:
   // freeze all three stages instead of wrapping.
   assign ovf_hit = min_carry;

   mod_counter #(.W(CS_W), .MAX(CS_MAX)) u_cs (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (clr_hit),
      .en     (run_tick),
      .frz    (ovf_hit),
      .cnt    (cs_cnt),
      .nxt    (cs_nxt),
      .carry  (cs_carry)
   );

   mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (clr_hit),
      .en     (cs_carry),
      .frz    (ovf_hit),
      .cnt    (sec_cnt),
      .nxt    (sec_nxt),
      .carry  (sec_carry)
   );

   mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (clr_hit),
      .en     (sec_carry),
      .frz    (ovf_hit),
      .cnt    (min_cnt),
      .nxt    (min_nxt),
      .carry  (min_carry)
   );

   always_comb begin
      live_q   = '{min: min_cnt, sec: sec_cnt, cs: cs_cnt};
      live_nxt = '{min: min_nxt, sec: sec_nxt, cs: cs_nxt};
   end

   // Next-state logic. btn_clr is only meaningful in IDLE/PAUSE; in RUN/LAP
   // it is treated as absent.
   always_comb begin
      state_d = state_q;
      clr_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_clr) begin
               clr_hit = 1'b1;
            end else if (btn_ss) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (btn_ss) begin
               state_d = ST_PAUSE;
            end else if (btn_lap) begin
               state_d = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (btn_clr) begin
               clr_hit = 1'b1;
               state_d = ST_IDLE;
            end else if (btn_ss) begin
               state_d = ST_RUN;
            end
         end
         ST_LAP: begin
            if (btn_ss) begin
               state_d = ST_PAUSE;
            end else if (btn_lap) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Saturation overrides any button: the watch stops where it is.
      if (ovf_hit) begin
         state_d = ST_PAUSE;
      end
   end

   // Snapshot, status and display registers. The display is loaded from the
   // values the counter/FSM take on this edge, so outputs never lag the state.
   always_comb begin
      snap_d = snap_q;
      // Entering LAP captures the pre-edge count, i.e. without a same-edge tick.
      if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
         snap_d = live_q;
      end

      ovf_d = ovf_q | ovf_hit;
      if (clr_hit) begin
         ovf_d = 1'b0;
      end

      running_d  = is_running(state_d);
      lap_hold_d = (state_d == ST_LAP);
      disp_d     = lap_hold_d ? snap_d : live_nxt;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         snap_q     <= '0;
         disp_q     <= '0;
         running_q  <= 1'b0;
         lap_hold_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         disp_q     <= disp_d;
         running_q  <= running_d;
         lap_hold_q <= lap_hold_d;
         ovf_q      <= ovf_d;
      end
   end

   assign disp_cs  = disp_q.cs;
   assign disp_sec = disp_q.sec;
   assign disp_min = disp_q.min;
   assign running  = running_q;
   assign lap_hold = lap_hold_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Bench for chrono_ctrl: directed scenarios plus a random phase against a total-centisecond model.
// Minutes ceiling is lowered to 1 so the saturation case is reachable in a short run.
module tb_chrono_ctrl;

   localparam int MINM     = 1;
   localparam int TOT_MAX  = (MINM + 1) * 6000 - 1;   // 01:59.99
   localparam int S_IDLE   = 0;
   localparam int S_RUN    = 1;
   localparam int S_PAUSE  = 2;
   localparam int S_LAP    = 3;

   logic       clk_in  = 1'b0;
   logic       rst_n   = 1'b0;
   logic       tick    = 1'b0;
   logic       btn_ss  = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic [6:0] disp_cs;
   logic [5:0] disp_sec;
   logic [5:0] disp_min;
   logic       running;
   logic       lap_hold;
   logic       ovf;

   int errors = 0;
   int checks = 0;

   // Reference model: elapsed time as one integer of centiseconds.
   int m_st;
   int m_tot;
   int m_snap;
   bit m_ovf;

   chrono_ctrl #(.CS_MAX(99), .SEC_MAX(59), .MIN_MAX(MINM)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .tick     (tick),
      .btn_ss   (btn_ss),
      .btn_lap  (btn_lap),
      .btn_clr  (btn_clr),
      .disp_cs  (disp_cs),
      .disp_sec (disp_sec),
      .disp_min (disp_min),
      .running  (running),
      .lap_hold (lap_hold),
      .ovf      (ovf)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st   = S_IDLE;
      m_tot  = 0;
      m_snap = 0;
      m_ovf  = 0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit l, input bit c);
      int  nst;
      int  prev;
      bit  hit;
      nst  = m_st;
      prev = m_tot;
      hit  = 0;
      if ((m_st == S_RUN || m_st == S_LAP) && t) begin
         if (m_tot == TOT_MAX) begin
            hit   = 1;
            m_ovf = 1;
         end else begin
            m_tot = m_tot + 1;
         end
      end
      case (m_st)
         S_IDLE:  if (c) begin m_tot = 0; m_ovf = 0; end
                  else if (s) nst = S_RUN;
         S_RUN:   if (s) nst = S_PAUSE;
                  else if (l) nst = S_LAP;
         S_PAUSE: if (c) begin nst = S_IDLE; m_tot = 0; m_ovf = 0; end
                  else if (s) nst = S_RUN;
         default: if (s) nst = S_PAUSE;
                  else if (l) nst = S_RUN;
      endcase
      if (hit) nst = S_PAUSE;
      if (nst == S_LAP && m_st != S_LAP) m_snap = prev;
      m_st = nst;
   endtask

   task automatic check_all(input string tag);
      int shown;
      shown = (m_st == S_LAP) ? m_snap : m_tot;
      chk({tag, ".cs"},   32'(disp_cs),  32'(shown % 100));
      chk({tag, ".sec"},  32'(disp_sec), 32'((shown / 100) % 60));
      chk({tag, ".min"},  32'(disp_min), 32'(shown / 6000));
      chk({tag, ".run"},  32'(running),  32'(m_st == S_RUN || m_st == S_LAP));
      chk({tag, ".lap"},  32'(lap_hold), 32'(m_st == S_LAP));
      chk({tag, ".ovf"},  32'(ovf),      32'(m_ovf));
   endtask

   // One clock cycle: inputs driven from a negedge, outputs checked at the next negedge.
   task automatic cyc(input bit t, input bit s, input bit l, input bit c, input string tag);
      tick    = t;
      btn_ss  = s;
      btn_lap = l;
      btn_clr = c;
      @(posedge clk_in);
      model_step(t, s, l, c);
      @(negedge clk_in);
      tick    = 0;
      btn_ss  = 0;
      btn_lap = 0;
      btn_clr = 0;
      check_all(tag);
   endtask

   task automatic run_ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, tag);
   endtask

   // Bring the watch to IDLE with a zeroed counter from any state.
   task automatic go_idle();
      if (m_st == S_RUN || m_st == S_LAP) cyc(0, 1, 0, 0, "to_pause");
      cyc(0, 0, 0, 1, "to_idle");
   endtask

   initial begin
      m_reset();
      #12;
      check_all("reset");

      @(negedge clk_in);
      rst_n = 1'b1;

      // One minute of ticks from a fresh start; first edge after release is a normal cycle.
      cyc(0, 1, 0, 0, "start");
      run_ticks(6000, "min1");
      chk("min1_disp_min", 32'(disp_min), 32'd1);
      chk("min1_disp_sec", 32'(disp_sec), 32'd0);
      chk("min1_disp_cs",  32'(disp_cs),  32'd0);
      chk("min1_running",  32'(running),  32'd1);

      // Lap freezes the display while the live count keeps going.
      go_idle();
      cyc(0, 1, 0, 0, "start2");
      run_ticks(542, "to542");
      cyc(0, 0, 1, 0, "lap_in");
      run_ticks(100, "lap_hold");
      chk("lap_disp_sec", 32'(disp_sec), 32'd5);
      chk("lap_disp_cs",  32'(disp_cs),  32'd42);
      chk("lap_hold_hi",  32'(lap_hold), 32'd1);
      cyc(0, 0, 1, 0, "lap_out");
      chk("lapout_sec", 32'(disp_sec), 32'd6);
      chk("lapout_cs",  32'(disp_cs),  32'd42);

      // A tick coinciding with lap entry is counted live but not snapshotted.
      cyc(1, 0, 1, 0, "lap_tick");
      run_ticks(3, "lap_tick2");
      cyc(0, 1, 0, 0, "lap_pause");

      // Stop with a coincident tick: the tick counts, later ticks do not.
      go_idle();
      cyc(0, 1, 0, 0, "start3");
      run_ticks(9, "to9");
      cyc(1, 1, 0, 0, "ss_tick");
      chk("sstick_cs", 32'(disp_cs), 32'd10);
      run_ticks(50, "paused");
      chk("paused_cs", 32'(disp_cs), 32'd10);
      chk("paused_run", 32'(running), 32'd0);

      // Restart from PAUSE with a coincident tick: not counted.
      cyc(1, 1, 0, 0, "resume_tick");
      chk("resume_cs", 32'(disp_cs), 32'd10);

      // Clear is ignored while running; all three buttons in PAUSE clear to IDLE.
      cyc(0, 0, 0, 1, "clr_run");
      chk("clrrun_run", 32'(running), 32'd1);
      cyc(0, 1, 0, 0, "pause2");
      cyc(0, 1, 1, 1, "all_btn");
      chk("allbtn_cs", 32'(disp_cs), 32'd0);
      cyc(0, 0, 1, 0, "lap_idle");
      cyc(1, 0, 0, 0, "tick_idle");

      // Saturation at the ceiling, then clear.
      cyc(0, 1, 0, 0, "start4");
      run_ticks(TOT_MAX, "to_max");
      chk("max_min", 32'(disp_min), 32'(MINM));
      chk("max_cs",  32'(disp_cs),  32'd99);
      cyc(1, 0, 0, 0, "sat");
      chk("sat_ovf", 32'(ovf),      32'd1);
      chk("sat_cs",  32'(disp_cs),  32'd99);
      chk("sat_sec", 32'(disp_sec), 32'd59);
      chk("sat_run", 32'(running),  32'd0);
      run_ticks(5, "sat_hold");
      cyc(0, 0, 0, 1, "sat_clr");
      chk("satclr_ovf", 32'(ovf),     32'd0);
      chk("satclr_cs",  32'(disp_cs), 32'd0);

      // Saturation while in LAP.
      cyc(0, 1, 0, 0, "start5");
      run_ticks(TOT_MAX - 2, "to_max2");
      cyc(0, 0, 1, 0, "lap_max");
      run_ticks(4, "sat_lap");
      go_idle();

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 1) == 1),
             ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 13) == 0), "rand");
      end

      // Asynchronous reset in the middle of a lap.
      go_idle();
      cyc(0, 1, 0, 0, "start6");
      run_ticks(37, "to37");
      cyc(0, 0, 1, 0, "lap6");
      run_ticks(5, "lap6_hold");
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all("async_rst");
      @(negedge clk_in);
      check_all("rst_held");
      rst_n = 1'b1;
      cyc(0, 1, 0, 0, "start7");
      run_ticks(20, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/chrono_ctrl.md
CHRONO_CTRL -- requirements
Module: chrono_ctrl

Interface
REQ-001 Parameter CS_MAX, default 99: last centisecond value before carry.
REQ-002 Parameter SEC_MAX, default 59: last seconds value before carry.
REQ-003 Parameter MIN_MAX, default 59: last minutes value; the counter saturates here.
REQ-004 clk_in  input  1  system clock; every flop is clocked on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tick  input  1  one-cycle pulse per 1/100 s, from the divider.
REQ-007 btn_ss  input  1  one-cycle start/stop pulse, already debounced.
REQ-008 btn_lap  input  1  one-cycle lap pulse, already debounced.
REQ-009 btn_clr  input  1  one-cycle clear pulse, already debounced.
REQ-010 disp_cs  output  7  displayed centiseconds, range 0..CS_MAX.
REQ-011 disp_sec  output  6  displayed seconds, range 0..SEC_MAX.
REQ-012 disp_min  output  6  displayed minutes, range 0..MIN_MAX.
REQ-013 running  output  1  high in RUN and LAP.
REQ-014 lap_hold  output  1  high in LAP.
REQ-015 ovf  output  1  sticky saturation flag.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE and LAP; all outputs SHALL be registered.
REQ-017 Button priority when pulses coincide SHALL be btn_clr > btn_ss > btn_lap; only the highest-priority active button is acted on.
REQ-018 IDLE SHALL go to RUN on btn_ss; btn_lap is ignored in IDLE.
REQ-019 RUN SHALL go to PAUSE on btn_ss, and to LAP on btn_lap.
REQ-020 PAUSE SHALL go to RUN on btn_ss; btn_lap is ignored in PAUSE.
REQ-021 LAP SHALL go to RUN on btn_lap and to PAUSE on btn_ss.
REQ-022 btn_clr SHALL act only in PAUSE or IDLE: go to IDLE, zero the live counter and clear ovf; in RUN or LAP it is ignored.
REQ-023 The live counter SHALL advance by one centisecond on a clock edge where tick=1, using the state held before that edge being RUN or LAP; latency is 1 cycle.
REQ-024 A tick that coincides with btn_ss in RUN SHALL still be counted; a tick that coincides with btn_ss in IDLE or PAUSE SHALL not be counted.
REQ-025 Carry rules: cs wraps from CS_MAX to 0 and increments sec; sec wraps from SEC_MAX to 0 and increments min.
REQ-026 A tick at MIN_MAX:SEC_MAX:CS_MAX SHALL leave the counter unchanged, set ovf and move the FSM to PAUSE.
REQ-027 On entry to LAP, the snapshot registers SHALL capture the live counter value present before that edge, excluding any same-edge tick.
REQ-028 The disp_* outputs SHALL show the snapshot in LAP and the live counter in every other state, with one cycle of register latency.
REQ-029 On LAP->PAUSE, the display SHALL revert to the live counter.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, live counter 0, snapshot 0, all disp_* 0, running=0, lap_hold=0 and ovf=0.
REQ-031 Reset asserted during RUN or LAP SHALL discard the elapsed time.
REQ-032 Reset deassertion SHALL need no prior clock, and the first edge after release SHALL be treated as a normal cycle.

Structure
REQ-033 State encoding and the CS_MAX, SEC_MAX and MIN_MAX defaults SHALL live in the shared package chrono_pkg.
REQ-034 A single sub-module, mod_counter, SHALL be used: a parameterised modulo-N counter with enable input and carry output, instantiated three times in a cascade.
REQ-035 The divider SHALL be instantiated outside this block, and chrono_ctrl SHALL contain no clock gating.

Verification
REQ-036 Reset, then btn_ss, then 6000 ticks -> display 01:00.00, running=1.
REQ-037 RUN at 00:05.42, then btn_lap, then 100 ticks -> display stays 00:05.42, lap_hold=1; then btn_lap -> display 00:06.42 on the next cycle.
REQ-038 btn_ss and tick in the same cycle from RUN at 00:00.09 -> PAUSE showing 00:00.10; a further 50 ticks -> display unchanged.
REQ-039 Counter at 59:59.99, then tick -> display stays 59:59.99, ovf=1, state PAUSE; then btn_clr -> 00:00.00, ovf=0, state IDLE.
REQ-040 btn_clr during RUN -> ignored; btn_clr, btn_ss and btn_lap together in PAUSE -> IDLE with a zeroed counter.
REQ-041 rst_n pulled low mid-LAP between clock edges -> all outputs zero before the next edge.
